// File: rtl/pipe_hazard_pkg.sv
// Shared types, constants and width helpers for the pipeline hazard/forwarding unit.
package pipe_hazard_pkg;

    localparam int unsigned AW_DEF = 5;

    // Forwarding select encoding: 0 selects the register file, k selects source k-1.
    typedef enum logic [1:0] {
        FWD_RF   = 2'd0,
        FWD_SRC0 = 2'd1,
        FWD_SRC1 = 2'd2
    } fwd_sel_e;

    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;

    function automatic int unsigned sel_width(input int unsigned nsrc);
        return (nsrc < 1) ? 1 : $clog2(nsrc + 1);
    endfunction

    // Width of a down-counter that must hold max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-writeback scoreboard for long-latency ops with same-cycle completion bypass.
module hazard_scoreboard
    import pipe_hazard_pkg::*;
#(
    parameter int unsigned AW = AW_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_en,
    input  logic [AW-1:0]         set_rd,
    input  logic                  clr_en,
    input  logic [AW-1:0]         clr_rd,
    input  logic [AW-1:0]         rd_a,
    input  logic [AW-1:0]         rd_b,
    output logic                  pend_a_c,
    output logic                  pend_b_c,
    output logic [(1<<AW)-1:0]    busy
);

    localparam int unsigned NR = 1 << AW;

    logic [NR-1:0] busy_nxt;

    // Clear first so a same-register set in the same cycle wins.
    always_comb begin
        busy_nxt = busy;
        if (clr_en) begin
            busy_nxt[clr_rd] = 1'b0;
        end
        if (set_en && (set_rd != '0)) begin
            busy_nxt[set_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // A register being written back this cycle is no longer a hazard.
    always_comb begin
        pend_a_c = busy[rd_a] && !(clr_en && (clr_rd == rd_a));
        pend_b_c = busy[rd_b] && !(clr_en && (clr_rd == rd_b));
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller for the 5-stage RV32 pipeline.
// Define HAZARD_PERF_EN to add stall/flush cycle performance counters.
module pipe_hazard_unit
    import pipe_hazard_pkg::*;
#(
    parameter int unsigned AW         = AW_DEF,
    parameter int unsigned NFWD       = 2,
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned FLUSH_SHDW = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [AW-1:0]             if_rs1_i,
    input  logic [AW-1:0]             if_rs2_i,
    input  logic                      if_rs1_use_i,
    input  logic                      if_rs2_use_i,
    input  logic                      id_is_load_i,
    input  logic [AW-1:0]             id_rd_i,
    input  logic [AW-1:0]             id_rs1_i,
    input  logic [AW-1:0]             id_rs2_i,
    input  logic [AW-1:0]             ex_rs2_i,
    input  logic [NFWD*AW-1:0]        fwd_rd_i,
    input  logic [NFWD-1:0]           fwd_we_i,
    input  logic                      lop_issue_i,
    input  logic                      lop_done_i,
    input  logic [AW-1:0]             lop_done_rd_i,
    input  logic                      br_taken_i,
    input  logic                      jump_i,
    output logic                      stall_o,
    output logic                      if_id_flush_o,
    output logic                      ex_flush_o,
    output logic [sel_width(NFWD)-1:0] fwd_a_sel_o,
    output logic [sel_width(NFWD)-1:0] fwd_b_sel_o,
    output logic                      fwd_dmem_o,
    output logic [(1<<AW)-1:0]        sb_busy_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]               perf_stall_cnt_o,
    output logic [31:0]               perf_flush_cnt_o
`endif
);

    localparam int unsigned SELW = sel_width(NFWD);
    localparam int unsigned LUW  = cnt_width(LOAD_LAT - 1);
    localparam int unsigned FLW  = cnt_width(FLUSH_SHDW);
    localparam int unsigned NR   = 1 << AW;

    logic [LUW-1:0]  lu_cnt, lu_cnt_nxt;
    logic [FLW-1:0]  fl_cnt, fl_cnt_nxt;
    logic [SELW-1:0] fwd_a_sel_c, fwd_b_sel_c;
    logic            fwd_dmem_c;
    logic            detect_c, redirect_c, flush_act_c, sb_stall_c, stall_c;
    logic            pend_a_c, pend_b_c;
    logic [NR-1:0]   sb_busy;

    hazard_scoreboard #(.AW(AW)) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (lop_issue_i),
        .set_rd   (id_rd_i),
        .clr_en   (lop_done_i),
        .clr_rd   (lop_done_rd_i),
        .rd_a     (if_rs1_i),
        .rd_b     (if_rs2_i),
        .pend_a_c (pend_a_c),
        .pend_b_c (pend_b_c),
        .busy     (sb_busy)
    );

    // Youngest matching source wins: scan oldest to youngest, last hit kept.
    always_comb begin
        fwd_a_sel_c = SELW'(FWD_RF);
        fwd_b_sel_c = SELW'(FWD_RF);
        for (int k = int'(NFWD) - 1; k >= 0; k--) begin
            if (fwd_we_i[k] && (fwd_rd_i[k*AW +: AW] != '0)) begin
                if (fwd_rd_i[k*AW +: AW] == id_rs1_i) fwd_a_sel_c = SELW'(k + 1);
                if (fwd_rd_i[k*AW +: AW] == id_rs2_i) fwd_b_sel_c = SELW'(k + 1);
            end
        end
    end

    if (NFWD >= 2) begin : g_dmem
        assign fwd_dmem_c = fwd_we_i[1] && (fwd_rd_i[AW +: AW] != '0)
                            && (fwd_rd_i[AW +: AW] == ex_rs2_i);
    end else begin : g_no_dmem
        assign fwd_dmem_c = 1'b0;
    end

    // Stall/flush decision and counter next-state.
    always_comb begin
        detect_c    = id_is_load_i && (id_rd_i != '0)
                      && ((if_rs1_use_i && (if_rs1_i == id_rd_i))
                       || (if_rs2_use_i && (if_rs2_i == id_rd_i)));
        sb_stall_c  = (if_rs1_use_i && pend_a_c) || (if_rs2_use_i && pend_b_c);
        redirect_c  = br_taken_i || jump_i;
        flush_act_c = redirect_c || (fl_cnt != '0);
        stall_c     = !flush_act_c && (detect_c || (lu_cnt != '0) || sb_stall_c);

        lu_cnt_nxt = lu_cnt;
        if (flush_act_c) begin
            lu_cnt_nxt = '0;
        end else if (detect_c) begin
            lu_cnt_nxt = LUW'(LOAD_LAT - 1);
        end else if (lu_cnt != '0) begin
            lu_cnt_nxt = lu_cnt - LUW'(1);
        end

        fl_cnt_nxt = fl_cnt;
        if (redirect_c) begin
            fl_cnt_nxt = FLW'(FLUSH_SHDW);
        end else if (fl_cnt != '0) begin
            fl_cnt_nxt = fl_cnt - FLW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lu_cnt <= '0;
            fl_cnt <= '0;
        end else begin
            lu_cnt <= lu_cnt_nxt;
            fl_cnt <= fl_cnt_nxt;
        end
    end

    // Outputs held low while reset is asserted.
    always_comb begin
        stall_o       = rst_n && stall_c;
        if_id_flush_o = rst_n && flush_act_c;
        ex_flush_o    = rst_n && br_taken_i;
        fwd_a_sel_o   = rst_n ? fwd_a_sel_c : '0;
        fwd_b_sel_o   = rst_n ? fwd_b_sel_c : '0;
        fwd_dmem_o    = rst_n && fwd_dmem_c;
        sb_busy_o     = rst_n ? sb_busy : '0;
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_cnt_o <= '0;
            perf_flush_cnt_o <= '0;
        end else begin
            if (stall_o)       perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
            if (if_id_flush_o) perf_flush_cnt_o <= perf_flush_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit: directed scenarios then random stimulus vs a behavioural model.
module tb_pipe_hazard_unit;

    localparam int unsigned AW         = 5;
    localparam int unsigned NFWD       = 2;
    localparam int unsigned LOAD_LAT   = 2;
    localparam int unsigned FLUSH_SHDW = 1;
    localparam int unsigned NR         = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [AW-1:0]     if_rs1, if_rs2, id_rd, id_rs1, id_rs2, ex_rs2, lop_done_rd;
    logic              if_rs1_use, if_rs2_use, id_is_load, lop_issue, lop_done, br_taken, jump;
    logic [NFWD*AW-1:0] fwd_rd;
    logic [NFWD-1:0]   fwd_we;
    logic              stall, if_id_flush, ex_flush, fwd_dmem;
    logic [1:0]        fwd_a_sel, fwd_b_sel;
    logic [NR-1:0]     sb_busy;
`ifdef HAZARD_PERF_EN
    logic [31:0]       perf_stall_cnt, perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    pipe_hazard_unit #(.AW(AW), .NFWD(NFWD), .LOAD_LAT(LOAD_LAT), .FLUSH_SHDW(FLUSH_SHDW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_rs1_i      (if_rs1),
        .if_rs2_i      (if_rs2),
        .if_rs1_use_i  (if_rs1_use),
        .if_rs2_use_i  (if_rs2_use),
        .id_is_load_i  (id_is_load),
        .id_rd_i       (id_rd),
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .ex_rs2_i      (ex_rs2),
        .fwd_rd_i      (fwd_rd),
        .fwd_we_i      (fwd_we),
        .lop_issue_i   (lop_issue),
        .lop_done_i    (lop_done),
        .lop_done_rd_i (lop_done_rd),
        .br_taken_i    (br_taken),
        .jump_i        (jump),
        .stall_o       (stall),
        .if_id_flush_o (if_id_flush),
        .ex_flush_o    (ex_flush),
        .fwd_a_sel_o   (fwd_a_sel),
        .fwd_b_sel_o   (fwd_b_sel),
        .fwd_dmem_o    (fwd_dmem),
        .sb_busy_o     (sb_busy)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_cnt_o (perf_stall_cnt),
        .perf_flush_cnt_o (perf_flush_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: pending long-op destinations, remaining stall/flush cycles.
    bit          pend[NR];
    int          lu_left, fl_left;
    bit [31:0]   m_perf_s, m_perf_f;
    bit          e_stall, e_ifid, e_ex, e_dmem, e_det, e_flush;
    int          e_asel, e_bsel;
    bit [NR-1:0] e_busy;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int fwd_pick(input logic [AW-1:0] src);
        for (int k = 0; k < int'(NFWD); k++) begin
            if (fwd_we[k] && fwd_rd[k*AW +: AW] != 0 && fwd_rd[k*AW +: AW] == src) return k + 1;
        end
        return 0;
    endfunction

    function automatic bit sb_hit(input logic use_r, input logic [AW-1:0] r);
        return use_r && pend[r] && !(lop_done && lop_done_rd == r);
    endfunction

    task automatic model_comb();
        bit sbs;
        e_det   = id_is_load && id_rd != 0
                  && ((if_rs1_use && if_rs1 == id_rd) || (if_rs2_use && if_rs2 == id_rd));
        sbs     = sb_hit(if_rs1_use, if_rs1) || sb_hit(if_rs2_use, if_rs2);
        e_flush = br_taken || jump || fl_left > 0;
        e_stall = rst_n && !e_flush && (e_det || lu_left > 0 || sbs);
        e_ifid  = rst_n && e_flush;
        e_ex    = rst_n && br_taken;
        e_asel  = rst_n ? fwd_pick(id_rs1) : 0;
        e_bsel  = rst_n ? fwd_pick(id_rs2) : 0;
        e_dmem  = rst_n && fwd_we[1] && fwd_rd[AW +: AW] != 0 && fwd_rd[AW +: AW] == ex_rs2;
        e_busy  = '0;
        for (int r = 0; r < int'(NR); r++) e_busy[r] = rst_n && pend[r];
    endtask

    task automatic model_seq();
        if (!rst_n) begin
            for (int r = 0; r < int'(NR); r++) pend[r] = 1'b0;
            lu_left = 0; fl_left = 0; m_perf_s = 0; m_perf_f = 0;
        end else begin
            if (e_stall) m_perf_s = m_perf_s + 1;
            if (e_ifid)  m_perf_f = m_perf_f + 1;
            if (e_flush)    lu_left = 0;
            else if (e_det) lu_left = LOAD_LAT - 1;
            else if (lu_left > 0) lu_left = lu_left - 1;
            if (br_taken || jump) fl_left = FLUSH_SHDW;
            else if (fl_left > 0) fl_left = fl_left - 1;
            if (lop_done) pend[lop_done_rd] = 1'b0;
            if (lop_issue && id_rd != 0) pend[id_rd] = 1'b1;
        end
    endtask

    task automatic sample();
        #3;
        model_comb();
        check_eq("stall",    64'(stall),       64'(e_stall));
        check_eq("if_id_fl", 64'(if_id_flush), 64'(e_ifid));
        check_eq("ex_fl",    64'(ex_flush),    64'(e_ex));
        check_eq("fwd_a",    64'(fwd_a_sel),   64'(e_asel));
        check_eq("fwd_b",    64'(fwd_b_sel),   64'(e_bsel));
        check_eq("fwd_dmem", 64'(fwd_dmem),    64'(e_dmem));
        check_eq("sb_busy",  64'(sb_busy),     64'(e_busy));
`ifdef HAZARD_PERF_EN
        check_eq("perf_st",  64'(perf_stall_cnt), 64'(m_perf_s));
        check_eq("perf_fl",  64'(perf_flush_cnt), 64'(m_perf_f));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_seq();
        #1;
    endtask

    task automatic idle();
        rst_n = 1'b1;
        if_rs1 = '0; if_rs2 = '0; if_rs1_use = 0; if_rs2_use = 0;
        id_is_load = 0; id_rd = '0; id_rs1 = '0; id_rs2 = '0; ex_rs2 = '0;
        fwd_rd = '0; fwd_we = '0; lop_issue = 0; lop_done = 0; lop_done_rd = '0;
        br_taken = 0; jump = 0;
    endtask

    function automatic logic [AW-1:0] pick_reg();
        return AW'($urandom_range(0, 3));
    endfunction

    task automatic rand_inputs();
        rst_n      = ($urandom_range(0, 199) != 0);
        if_rs1     = pick_reg(); if_rs2 = pick_reg();
        if_rs1_use = 1'($urandom_range(0, 1)); if_rs2_use = 1'($urandom_range(0, 1));
        id_is_load = ($urandom_range(0, 3) == 0);
        id_rd      = pick_reg(); id_rs1 = pick_reg(); id_rs2 = pick_reg(); ex_rs2 = pick_reg();
        fwd_rd     = {pick_reg(), pick_reg()};
        fwd_we     = 2'($urandom_range(0, 3));
        lop_issue  = ($urandom_range(0, 7) == 0);
        lop_done   = ($urandom_range(0, 3) == 0);
        lop_done_rd = pick_reg();
        br_taken   = ($urandom_range(0, 15) == 0);
        jump       = ($urandom_range(0, 15) == 0);
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        for (int r = 0; r < int'(NR); r++) pend[r] = 1'b0;
        lu_left = 0; fl_left = 0; m_perf_s = 0; m_perf_f = 0;
        repeat (2) @(posedge clk);
        #1;
        sample();
        check_eq("rst_stall", 64'(stall), 64'd0);
        tick();

        // Load-use: ld x5 in ID, IF reads x5/x7; two stall cycles then release.
        idle(); id_is_load = 1; id_rd = 5; if_rs1 = 5; if_rs2 = 7; if_rs1_use = 1; if_rs2_use = 1;
        sample(); check_eq("lu_c0", 64'(stall), 64'd1); tick();
        id_is_load = 0;
        sample(); check_eq("lu_c1", 64'(stall), 64'd1); tick();
        sample(); check_eq("lu_c2", 64'(stall), 64'd0); tick();
        id_is_load = 1; id_rd = 0; if_rs1 = 0;
        sample(); check_eq("lu_x0", 64'(stall), 64'd0); tick();

        // Forwarding priority and x0 exclusion.
        idle(); fwd_we = 2'b11; fwd_rd = {5'd3, 5'd3}; id_rs1 = 3; ex_rs2 = 3;
        sample(); check_eq("fwd_young", 64'(fwd_a_sel), 64'd1);
        check_eq("fwd_dmem1", 64'(fwd_dmem), 64'd1); tick();
        fwd_we = 2'b10;
        sample(); check_eq("fwd_old", 64'(fwd_a_sel), 64'd2); tick();
        fwd_we = 2'b11; fwd_rd = '0; id_rs1 = 0; ex_rs2 = 0;
        sample(); check_eq("fwd_x0", 64'(fwd_a_sel), 64'd0);
        check_eq("fwd_dmem0", 64'(fwd_dmem), 64'd0); tick();

        // Scoreboard: mul x9 pending until writeback, bypass on the done cycle.
        idle(); lop_issue = 1; id_rd = 9;
        sample(); tick();
        lop_issue = 0; id_rd = 0; if_rs1 = 9; if_rs1_use = 1;
        sample(); check_eq("sb_st0", 64'(stall), 64'd1);
        check_eq("sb_bit9", 64'(sb_busy[9]), 64'd1); tick();
        sample(); check_eq("sb_st1", 64'(stall), 64'd1); tick();
        lop_done = 1; lop_done_rd = 9;
        sample(); check_eq("sb_byp", 64'(stall), 64'd0); tick();
        lop_done = 0;
        sample(); check_eq("sb_clr", 64'(sb_busy[9]), 64'd0);
        check_eq("sb_st2", 64'(stall), 64'd0); tick();

        // Taken branch with a concurrent load-use hazard.
        idle(); br_taken = 1; id_is_load = 1; id_rd = 4; if_rs1 = 4; if_rs1_use = 1;
        sample(); check_eq("br_stall", 64'(stall), 64'd0);
        check_eq("br_ex0", 64'(ex_flush), 64'd1);
        check_eq("br_ifid0", 64'(if_id_flush), 64'd1); tick();
        br_taken = 0;
        sample(); check_eq("br_ex1", 64'(ex_flush), 64'd0);
        check_eq("br_ifid1", 64'(if_id_flush), 64'd1);
        check_eq("br_stall1", 64'(stall), 64'd0); tick();
        id_is_load = 0;
        sample(); check_eq("br_ifid2", 64'(if_id_flush), 64'd0);
        check_eq("br_stall2", 64'(stall), 64'd0); tick();

        // Reset while a long op is pending and a flush shadow is live.
        idle(); lop_issue = 1; id_rd = 9;
        sample(); tick();
        idle(); br_taken = 1;
        sample(); tick();
        idle(); rst_n = 0;
        sample(); check_eq("rst_ifid", 64'(if_id_flush), 64'd0); tick();
        idle();
        sample(); check_eq("rst_sb", 64'(sb_busy), 64'd0);
        check_eq("rst_ifid2", 64'(if_id_flush), 64'd0);
`ifdef HAZARD_PERF_EN
        check_eq("rst_perf", 64'(perf_stall_cnt), 64'd0);
`endif
        tick();

        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            sample();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
